// File: rtl/encoders_pkg.sv
// encoders_pkg: shared state encoding and default widths for the scan encoders
package encoders_pkg;
    localparam int N_IN_DEF  = 16;
    localparam int W_OUT_DEF = 4;
    typedef enum logic [1:0] {IDLE, SCAN, NONE} state_t;
endpackage

// File: rtl/b16to4_prio_encoder.sv
// b16to4_prio_encoder: combinational priority encoder, pending -> {any, code}
module b16to4_prio_encoder
    import encoders_pkg::*;
#(
    parameter int N_IN         = N_IN_DEF,
    parameter int W_OUT        = W_OUT_DEF,
    parameter int PRIORITY_MSB = 0
) (
    input  logic [N_IN-1:0]  pending,
    output logic             any,
    output logic [W_OUT-1:0] code
);
    // Walk from the low-priority end so the last hit is the winning bit
    always_comb begin
        any  = |pending;
        code = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (PRIORITY_MSB != 0 ? pending[i] : pending[N_IN-1-i])
                code = W_OUT'(PRIORITY_MSB != 0 ? i : N_IN-1-i);
        end
    end
endmodule

// File: rtl/b16to4_scan_encoder.sv
// b16to4_scan_encoder: serialises a multi-hot request vector into one index per beat
module b16to4_scan_encoder
    import encoders_pkg::*;
#(
    parameter int N_IN         = N_IN_DEF,
    parameter int W_OUT        = W_OUT_DEF,
    parameter int PRIORITY_MSB = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_IN-1:0]  x15_x0,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W_OUT-1:0] z3_z0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_none
);
    state_t            state, next;
    logic [N_IN-1:0]   pending, pending_nxt;
    logic              any;
    logic              single;
    logic [W_OUT-1:0]  code;

    b16to4_prio_encoder #(
        .N_IN(N_IN),
        .W_OUT(W_OUT),
        .PRIORITY_MSB(PRIORITY_MSB)
    ) u_prio (
        .pending(pending),
        .any(any),
        .code(code)
    );

    // Clearing the lowest set bit leaves zero only when at most one bit was set
    assign single = (pending & (pending - N_IN'(1))) == '0;

    // State and pending register; reset drops any vector in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            state   <= next;
            pending <= pending_nxt;
        end
    end

    // Next state, bit-clear on each accepted beat, outputs from registered state only
    always_comb begin
        next        = state;
        pending_nxt = pending;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        z3_z0       = '0;
        out_last    = 1'b0;
        out_none    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pending_nxt = x15_x0;
                    next        = (x15_x0 == '0) ? NONE : SCAN;
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                z3_z0     = code;
                out_last  = single;
                if (out_ready) begin
                    pending_nxt = pending & ~(N_IN'(1) << code);
                    if (single || !any) next = IDLE;
                end
            end
            NONE: begin
                out_valid = 1'b1;
                out_none  = 1'b1;
                out_last  = 1'b1;
                if (out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_b16to4_scan_encoder.sv
// tb_b16to4_scan_encoder: LSB-first and MSB-first encoders checked against a per-vector index list model
module tb_b16to4_scan_encoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] x15_x0 = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        l_in_ready, l_out_valid, l_out_last, l_out_none;
    logic        m_in_ready, m_out_valid, m_out_last, m_out_none;
    logic [3:0]  l_z, m_z;
    int          checks = 0;
    int          failures = 0;

    b16to4_scan_encoder #(.PRIORITY_MSB(0)) dut_l (
        .clock(clock), .reset(reset), .x15_x0(x15_x0), .in_valid(in_valid),
        .in_ready(l_in_ready), .z3_z0(l_z), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .out_none(l_out_none)
    );

    b16to4_scan_encoder #(.PRIORITY_MSB(1)) dut_m (
        .clock(clock), .reset(reset), .x15_x0(x15_x0), .in_valid(in_valid),
        .in_ready(m_in_ready), .z3_z0(m_z), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .out_none(m_out_none)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " in_ready_l"}, 16'(l_in_ready), 16'd1);
        chk({tag, " in_ready_m"}, 16'(m_in_ready), 16'd1);
        chk({tag, " out_valid_l"}, 16'(l_out_valid), 16'd0);
        chk({tag, " out_valid_m"}, 16'(m_out_valid), 16'd0);
        chk({tag, " out_last_l"}, 16'(l_out_last), 16'd0);
        chk({tag, " out_none_m"}, 16'(m_out_none), 16'd0);
    endtask

    // mode 0: always ready; 1: stall 3 cycles then ready; 2: random ready and random ghost inputs
    // abort_after > 0: reset asynchronously once that many beats were accepted
    task automatic send(input string tag, input logic [15:0] v, input int mode, input int abort_after);
        int ql[$];
        int qm[$];
        int n, idx, c;
        bit zero, rdy;
        for (int i = 0; i < 16; i++) if (v[i]) ql.push_back(i);
        for (int i = 15; i >= 0; i--) if (v[i]) qm.push_back(i);
        zero = (v == 16'h0);
        n = zero ? 1 : ql.size();
        c = 0;
        while (!(l_in_ready && m_in_ready) && c < 20) begin
            @(negedge clock);
            c++;
        end
        chk({tag, " accept_ready"}, 16'(l_in_ready & m_in_ready), 16'd1);
        x15_x0 = v;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        chk({tag, " busy_l"}, 16'(l_in_ready), 16'd0);
        chk({tag, " busy_m"}, 16'(m_in_ready), 16'd0);
        idx = 0;
        c = 0;
        while (idx < n && c < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c >= 3) : 1'($urandom_range(0, 1));
            in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : (c == 1);
            x15_x0 = (mode == 2) ? 16'($urandom) : 16'h0002;
            out_ready = rdy;
            chk($sformatf("%s b%0d valid_l", tag, idx), 16'(l_out_valid), 16'd1);
            chk($sformatf("%s b%0d valid_m", tag, idx), 16'(m_out_valid), 16'd1);
            chk($sformatf("%s b%0d z_l", tag, idx), 16'(l_z), zero ? 16'd0 : 16'(ql[idx]));
            chk($sformatf("%s b%0d z_m", tag, idx), 16'(m_z), zero ? 16'd0 : 16'(qm[idx]));
            chk($sformatf("%s b%0d last_l", tag, idx), 16'(l_out_last), 16'(idx == n - 1));
            chk($sformatf("%s b%0d last_m", tag, idx), 16'(m_out_last), 16'(idx == n - 1));
            chk($sformatf("%s b%0d none_l", tag, idx), 16'(l_out_none), 16'(zero));
            chk($sformatf("%s b%0d none_m", tag, idx), 16'(m_out_none), 16'(zero));
            chk($sformatf("%s b%0d inrdy", tag, idx), 16'(l_in_ready | m_in_ready), 16'd0);
            @(negedge clock);
            in_valid = 1'b0;
            if (rdy) idx++;
            c++;
            if (abort_after > 0 && idx == abort_after) begin
                out_ready = 1'b0;
                #1 reset = 1'b1;
                #1;
                chk({tag, " rst_valid_l"}, 16'(l_out_valid), 16'd0);
                chk({tag, " rst_valid_m"}, 16'(m_out_valid), 16'd0);
                chk({tag, " rst_z"}, 16'({l_z, m_z}), 16'd0);
                @(negedge clock);
                reset = 1'b0;
                @(negedge clock);
                chk_idle({tag, " post_rst"});
                return;
            end
        end
        chk({tag, " beat_budget"}, 16'(idx), 16'(n));
        out_ready = 1'b0;
        chk_idle({tag, " done"});
    endtask

    initial begin
        #2;
        chk("reset valid_l", 16'(l_out_valid), 16'd0);
        chk("reset valid_m", 16'(m_out_valid), 16'd0);
        chk("reset z", 16'({l_z, m_z}), 16'd0);
        chk("reset last_none", 16'({l_out_last, l_out_none, m_out_last, m_out_none}), 16'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_idle("after_reset");
        send("t1_0001", 16'h0001, 0, 0);
        send("t2_8421", 16'h8421, 0, 0);
        send("t3_zero", 16'h0000, 0, 0);
        send("t4_0300", 16'h0300, 1, 0);
        send("t5_ffff", 16'hFFFF, 0, 3);
        send("t5_0010", 16'h0010, 0, 0);
        send("t6_8421", 16'h8421, 1, 0);
        send("t_8000", 16'h8000, 2, 0);
        send("t_zero_stall", 16'h0000, 1, 0);
        for (int k = 0; k < 40; k++) begin
            logic [15:0] v;
            case (k % 4)
                0: v = 16'($urandom);
                1: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2: v = 16'(1) << $urandom_range(0, 15);
                default: v = (k % 8 == 3) ? 16'h0000 : 16'($urandom) | 16'($urandom);
            endcase
            send($sformatf("rnd%0d", k), v, 2, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
